vga_scene_sequencer: RTL and testbench

- Frame-synchronous controller sitting between the game logic and the VGA pixel generator.
- Tracks both players' scores and runs the screen sequence: title, play, point-flash, game-over.
- Presents scene select, scores, flash enable and winner to the pixel generator.
- All display-facing outputs change only at the start of vertical sync, so no frame ever shows mixed content.

---
 rtl/vga_scene_sequencer_if.sv | 42 ++++
 rtl/vga_scene_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_vga_scene_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scene_sequencer_if.sv
// rtl/vga_scene_sequencer_if.sv - signal bundle between game logic, VGA timing and the scene sequencer
//
// Purpose: groups the frame-sync input, the game event pulses and the display-facing
// fields into one bundle so the sequencer and its surroundings connect with one port.
//
// Signals:
//   vsync       vertical sync from the VGA timing controller, active-low pulse
//   start       one-cycle start/confirm pulse (debounced upstream)
//   score0_evt  one-cycle pulse, player 0 scored
//   score1_evt  one-cycle pulse, player 1 scored
//   scene       0=TITLE 1=PLAY 2=POINT 3=OVER
//   score0      displayed score, player 0
//   score1      displayed score, player 1
//   flash_on    blink enable for the score digits
//   winner      0=none 1=player 0 2=player 1 3=draw
//   frame_tick  one-cycle pulse per vsync falling edge
//
// Modports:
//   master  game/timing side: drives vsync, start and score pulses, observes display fields
//   slave   sequencer side: observes the pulses, drives display fields and frame_tick
interface vga_scene_sequencer_if;
   logic       vsync;
   logic       start;
   logic       score0_evt;
   logic       score1_evt;
   logic [1:0] scene;
   logic [3:0] score0;
   logic [3:0] score1;
   logic       flash_on;
   logic [1:0] winner;
   logic       frame_tick;

   modport master (
      output vsync, start, score0_evt, score1_evt,
      input  scene, score0, score1, flash_on, winner, frame_tick
   );

   modport slave (
      input  vsync, start, score0_evt, score1_evt,
      output scene, score0, score1, flash_on, winner, frame_tick
   );
endinterface

// File: rtl/vga_scene_sequencer.sv
// rtl/vga_scene_sequencer.sv - frame-synchronous scene and score sequencer for the VGA pixel generator
//
// Purpose: tracks both players' scores and steps the screen through title, play,
// point-flash and game-over. Every display-facing field is a shadow register that
// only reloads on the frame_tick cycle, so a single frame never mixes old and new content.
//
// Ports:
//   clk   25 MHz pixel clock, same domain as the VGA timing controller
//   rst   synchronous reset, active-low
//   bus   slave side of vga_scene_sequencer_if (vsync/start/score pulses in,
//         scene/score0/score1/flash_on/winner/frame_tick out)
module vga_scene_sequencer #(
   parameter int WIN_SCORE    = 7,
   parameter int FLASH_FRAMES = 60,
   parameter int BLINK_FRAMES = 8,
   parameter int OVER_FRAMES  = 180
) (
   input  logic                  clk,
   input  logic                  rst,
   vga_scene_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_POINT = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam logic [3:0] WIN_C   = 4'(WIN_SCORE);
   localparam logic [7:0] FLASH_C = 8'(FLASH_FRAMES);
   localparam logic [7:0] BLINK_C = 8'(BLINK_FRAMES);
   localparam logic [7:0] OVER_C  = 8'(OVER_FRAMES);

   // game state
   state_t     state_q, state_d;
   logic [3:0] score0_q, score0_d;
   logic [3:0] score1_q, score1_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic [7:0] blink_cnt_q, blink_cnt_d;
   logic       flash_q, flash_d;
   logic [1:0] winner_q, winner_d;

   // frame sync
   logic       vsync_prev_q, vsync_prev_d;
   logic       frame_tick_q, frame_tick_d;

   // display shadows
   logic [1:0] disp_scene_q, disp_scene_d;
   logic [3:0] disp_score0_q, disp_score0_d;
   logic [3:0] disp_score1_q, disp_score1_d;
   logic       disp_flash_q, disp_flash_d;
   logic [1:0] disp_winner_q, disp_winner_d;

   logic       any_evt;
   logic       win0;
   logic       win1;
   logic       blink_last;
   logic       timed_state;

   assign any_evt     = bus.score0_evt | bus.score1_evt;
   assign win0        = (score0_q == WIN_C);
   assign win1        = (score1_q == WIN_C);
   assign blink_last  = ((blink_cnt_q + 8'd1) == BLINK_C);
   assign timed_state = (state_q == ST_POINT) || (state_q == ST_OVER);

   always_comb begin
      state_d       = state_q;
      score0_d      = score0_q;
      score1_d      = score1_q;
      frame_cnt_d   = frame_cnt_q;
      blink_cnt_d   = blink_cnt_q;
      flash_d       = flash_q;
      winner_d      = winner_q;
      disp_scene_d  = disp_scene_q;
      disp_score0_d = disp_score0_q;
      disp_score1_d = disp_score1_q;
      disp_flash_d  = disp_flash_q;
      disp_winner_d = disp_winner_q;

      // Falling edge of vsync seen between the previous and current sample.
      vsync_prev_d = bus.vsync;
      frame_tick_d = vsync_prev_q & ~bus.vsync;

      // Shadows capture the values as they stand before this edge's transition,
      // so a state change on a tick cycle shows up one frame later.
      if (frame_tick_q) begin
         disp_scene_d  = state_q;
         disp_score0_d = score0_q;
         disp_score1_d = score1_q;
         disp_flash_d  = flash_q;
         disp_winner_d = winner_q;
      end

      // POINT and OVER share the frame counter and the blink divider.
      if (timed_state && frame_tick_q) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
         if (blink_last) begin
            blink_cnt_d = 8'd0;
            flash_d     = ~flash_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            // start wins over a coincident score pulse, which is simply dropped
            if (bus.start) begin
               state_d  = ST_PLAY;
               score0_d = 4'd0;
               score1_d = 4'd0;
               winner_d = 2'd0;
            end
         end

         ST_PLAY: begin
            if (any_evt) begin
               if (bus.score0_evt && (score0_q < WIN_C)) begin
                  score0_d = score0_q + 4'd1;
               end
               if (bus.score1_evt && (score1_q < WIN_C)) begin
                  score1_d = score1_q + 4'd1;
               end
               state_d     = ST_POINT;
               frame_cnt_d = 8'd0;
               blink_cnt_d = 8'd0;
               flash_d     = 1'b1;
            end
         end

         ST_POINT: begin
            if (frame_tick_q && (frame_cnt_d == FLASH_C)) begin
               if (win0 || win1) begin
                  state_d     = ST_OVER;
                  frame_cnt_d = 8'd0;
                  blink_cnt_d = 8'd0;
                  flash_d     = 1'b1;
                  winner_d    = {win1, win0};
               end else begin
                  state_d = ST_PLAY;
                  flash_d = 1'b0;
               end
            end
         end

         ST_OVER: begin
            // scores and winner stay put so the title screen can still show them
            if (bus.start || (frame_tick_q && (frame_cnt_d == OVER_C))) begin
               state_d = ST_IDLE;
               flash_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         score0_q      <= 4'd0;
         score1_q      <= 4'd0;
         frame_cnt_q   <= 8'd0;
         blink_cnt_q   <= 8'd0;
         flash_q       <= 1'b0;
         winner_q      <= 2'd0;
         vsync_prev_q  <= 1'b1;
         frame_tick_q  <= 1'b0;
         disp_scene_q  <= 2'd0;
         disp_score0_q <= 4'd0;
         disp_score1_q <= 4'd0;
         disp_flash_q  <= 1'b0;
         disp_winner_q <= 2'd0;
      end else begin
         state_q       <= state_d;
         score0_q      <= score0_d;
         score1_q      <= score1_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         flash_q       <= flash_d;
         winner_q      <= winner_d;
         vsync_prev_q  <= vsync_prev_d;
         frame_tick_q  <= frame_tick_d;
         disp_scene_q  <= disp_scene_d;
         disp_score0_q <= disp_score0_d;
         disp_score1_q <= disp_score1_d;
         disp_flash_q  <= disp_flash_d;
         disp_winner_q <= disp_winner_d;
      end
   end

   assign bus.scene      = disp_scene_q;
   assign bus.score0     = disp_score0_q;
   assign bus.score1     = disp_score1_q;
   assign bus.flash_on   = disp_flash_q;
   assign bus.winner     = disp_winner_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// tb/tb_vga_scene_sequencer.sv - randomized self-checking bench for vga_scene_sequencer
module tb_vga_scene_sequencer;
   localparam int WIN   = 7;
   localparam int FLASH = 60;
   localparam int BLINK = 8;
   localparam int OVER  = 180;

   logic clk = 1'b0;
   logic rst;
   logic vsync;
   logic start;
   logic e0;
   logic e1;

   int n_chk = 0;
   int n_err = 0;

   vga_scene_sequencer_if bus();
   assign bus.vsync      = vsync;
   assign bus.start      = start;
   assign bus.score0_evt = e0;
   assign bus.score1_evt = e1;

   vga_scene_sequencer #(
      .WIN_SCORE(WIN), .FLASH_FRAMES(FLASH), .BLINK_FRAMES(BLINK), .OVER_FRAMES(OVER)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial forever #5 clk = ~clk;

   // 20-cycle frame, vsync low for 3 cycles
   initial begin
      vsync = 1'b1;
      forever begin
         repeat (17) @(negedge clk);
         vsync = 1'b0;
         repeat (3) @(negedge clk);
         vsync = 1'b1;
      end
   end

   // Reference model: game phase 0..3, integer scores, frames since entering the
   // timed phase; flash derived from the frame count parity of BLINK-sized chunks.
   int m_phase, m_s0, m_s1, m_frames, m_win;
   int d_scene, d_s0, d_s1, d_flash, d_win;
   bit m_prev_v, m_tick;
   int n_phase, n_s0, n_s1, n_frames, n_win;
   int nd_scene, nd_s0, nd_s1, nd_flash, nd_win;
   bit n_prev_v, n_tick;
   int m_flash;

   always_comb begin
      m_flash  = ((m_phase == 2 || m_phase == 3) && ((m_frames / BLINK) % 2 == 0)) ? 1 : 0;
      n_phase  = m_phase;
      n_s0     = m_s0;
      n_s1     = m_s1;
      n_frames = m_frames;
      n_win    = m_win;
      nd_scene = d_scene;
      nd_s0    = d_s0;
      nd_s1    = d_s1;
      nd_flash = d_flash;
      nd_win   = d_win;
      n_prev_v = vsync;
      n_tick   = m_prev_v && !vsync;
      if (m_tick) begin
         nd_scene = m_phase;
         nd_s0    = m_s0;
         nd_s1    = m_s1;
         nd_flash = m_flash;
         nd_win   = m_win;
      end
      case (m_phase)
         0: if (start) begin
               n_phase = 1; n_s0 = 0; n_s1 = 0; n_win = 0;
            end
         1: if (e0 || e1) begin
               if (e0) n_s0 = (m_s0 + 1 > WIN) ? WIN : m_s0 + 1;
               if (e1) n_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
               n_phase  = 2;
               n_frames = 0;
            end
         2: if (m_tick) begin
               n_frames = m_frames + 1;
               if (n_frames == FLASH) begin
                  if (m_s0 == WIN || m_s1 == WIN) begin
                     n_phase  = 3;
                     n_frames = 0;
                     n_win    = (m_s0 == WIN ? 1 : 0) + (m_s1 == WIN ? 2 : 0);
                  end else begin
                     n_phase = 1;
                  end
               end
            end
         default: begin
            if (m_tick) n_frames = m_frames + 1;
            if (start || n_frames == OVER) n_phase = 0;
         end
      endcase
   end

   always @(posedge clk) begin
      if (!rst) begin
         m_phase <= 0; m_s0 <= 0; m_s1 <= 0; m_frames <= 0; m_win <= 0;
         d_scene <= 0; d_s0 <= 0; d_s1 <= 0; d_flash <= 0; d_win <= 0;
         m_prev_v <= 1'b1; m_tick <= 1'b0;
      end else begin
         m_phase <= n_phase; m_s0 <= n_s0; m_s1 <= n_s1; m_frames <= n_frames; m_win <= n_win;
         d_scene <= nd_scene; d_s0 <= nd_s0; d_s1 <= nd_s1; d_flash <= nd_flash; d_win <= nd_win;
         m_prev_v <= n_prev_v; m_tick <= n_tick;
      end
   end

   logic [13:0] mdl_vec;
   logic [13:0] dut_vec;
   assign mdl_vec = {2'(d_scene), 4'(d_s0), 4'(d_s1), 1'(d_flash), 2'(d_win), m_tick};
   assign dut_vec = {bus.scene, bus.score0, bus.score1, bus.flash_on, bus.winner, bus.frame_tick};

   task automatic test_reset;
      int ticks;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (dut_vec !== 14'd0) begin
         n_err++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
      end
      rst = 1'b1;
      ticks = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.frame_tick === 1'b1) ticks++;
         n_chk++;
         if (dut_vec !== mdl_vec) begin
            n_err++; $display("FAIL idle_cycle: got %h want %h", dut_vec, mdl_vec);
         end
      end
      n_chk++;
      if (ticks != 5) begin
         n_err++; $display("FAIL idle_tick_count: got %0d want 5", ticks);
      end
      n_chk++;
      if ({bus.scene, bus.score0, bus.score1, bus.winner} !== 12'd0) begin
         n_err++; $display("FAIL idle_fields: scene=%0d s0=%0d s1=%0d win=%0d want 0", bus.scene, bus.score0, bus.score1, bus.winner);
      end
   endtask

   task automatic test_point_flash;
      int ticks;
      bit was_tick;
      repeat ($urandom_range(1, 15)) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat ($urandom_range(2, 30)) @(negedge clk);
      for (int i = 0; i < 4 && m_tick; i++) @(negedge clk);
      e0 = 1'b1; @(negedge clk); e0 = 1'b0;
      ticks = 0;
      was_tick = 1'b0;
      for (int i = 0; i < 1500 && ticks < 61; i++) begin
         if (was_tick) begin
            ticks++;
            if (ticks == 1) begin
               n_chk++;
               if ({bus.scene, bus.score0, bus.flash_on} !== {2'd2, 4'd1, 1'b1}) begin
                  n_err++; $display("FAIL point_entry: scene/s0/flash=%0d/%0d/%0d want 2/1/1", bus.scene, bus.score0, bus.flash_on);
               end
            end
            if (ticks == 8 || ticks == 9) begin
               n_chk++;
               if (bus.flash_on !== (ticks == 8)) begin
                  n_err++; $display("FAIL point_blink%0d: got %0d want %0d", ticks, bus.flash_on, ticks == 8);
               end
            end
            if (ticks == 60 || ticks == 61) begin
               n_chk++;
               if (bus.scene !== ((ticks == 60) ? 2'd2 : 2'd1)) begin
                  n_err++; $display("FAIL point_exit%0d: scene got %0d want %0d", ticks, bus.scene, (ticks == 60) ? 2 : 1);
               end
            end
         end
         n_chk++;
         if (dut_vec !== mdl_vec) begin
            n_err++; $display("FAIL point_cycle: got %h want %h", dut_vec, mdl_vec);
         end
         was_tick = m_tick;
         @(negedge clk);
      end
      n_chk++;
      if (ticks < 61) begin
         n_err++; $display("FAIL point_timeout: ticks got %0d want 61", ticks);
      end
   endtask

   task automatic test_event_on_tick;
      int ticks;
      bit was_tick;
      for (int i = 0; i < 40 && !m_tick; i++) @(negedge clk);
      e1 = 1'b1; @(negedge clk); e1 = 1'b0;
      n_chk++;
      if (bus.scene !== 2'd1 || bus.score1 !== 4'd0) begin
         n_err++; $display("FAIL evt_on_tick: scene/s1=%0d/%0d want 1/0", bus.scene, bus.score1);
      end
      ticks = 0;
      was_tick = 1'b0;
      for (int i = 0; i < 1500 && ticks < 61; i++) begin
         e0 = 1'b0; e1 = 1'b0;
         if (was_tick) begin
            ticks++;
            if (ticks == 1) begin
               n_chk++;
               if (bus.scene !== 2'd2 || bus.score1 !== 4'd1) begin
                  n_err++; $display("FAIL evt_next_tick: scene/s1=%0d/%0d want 2/1", bus.scene, bus.score1);
               end
            end
            if (ticks == 61) begin
               n_chk++;
               if ({bus.scene, bus.score0, bus.score1} !== {2'd1, 4'd1, 4'd1}) begin
                  n_err++; $display("FAIL point_ignore: scene/s0/s1=%0d/%0d/%0d want 1/1/1", bus.scene, bus.score0, bus.score1);
               end
            end
         end
         n_chk++;
         if (dut_vec !== mdl_vec) begin
            n_err++; $display("FAIL evt_cycle: got %h want %h", dut_vec, mdl_vec);
         end
         if (ticks >= 1 && ticks < 50 && $urandom_range(0, 7) == 0) begin
            e0 = 1'($urandom_range(0, 1));
            e1 = ~e0;
         end
         was_tick = m_tick;
         @(negedge clk);
      end
      e0 = 1'b0; e1 = 1'b0;
   endtask

   task automatic test_draw;
      bit done;
      int r;
      done = 1'b0;
      for (int i = 0; i < 20000 && !done; i++) begin
         @(negedge clk);
         e0 = 1'b0; e1 = 1'b0;
         n_chk++;
         if (dut_vec !== mdl_vec) begin
            n_err++; $display("FAIL draw_cycle: got %h want %h", dut_vec, mdl_vec);
         end
         if (m_phase == 1 && $urandom_range(0, 7) == 0) begin
            r = int'($urandom_range(0, 2));
            if (m_s0 == 6 && m_s1 == 6) begin
               e0 = 1'b1; e1 = 1'b1;
            end else begin
               e0 = (m_s0 < 6) && (r != 1);
               e1 = (m_s1 < 6) && (r != 0);
            end
         end
         done = (d_scene == 3);
      end
      e0 = 1'b0; e1 = 1'b0;
      n_chk++;
      if ({bus.scene, bus.score0, bus.score1, bus.flash_on, bus.winner} !== {2'd3, 4'd7, 4'd7, 1'b1, 2'd3}) begin
         n_err++; $display("FAIL draw_over: scene/s0/s1/flash/win=%0d/%0d/%0d/%0d/%0d want 3/7/7/1/3",
                           bus.scene, bus.score0, bus.score1, bus.flash_on, bus.winner);
      end
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int i = 0; i < 40 && !m_tick; i++) @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({bus.scene, bus.score0, bus.score1, bus.flash_on, bus.winner} !== {2'd0, 4'd7, 4'd7, 1'b0, 2'd3}) begin
         n_err++; $display("FAIL over_start: scene/s0/s1/flash/win=%0d/%0d/%0d/%0d/%0d want 0/7/7/0/3",
                           bus.scene, bus.score0, bus.score1, bus.flash_on, bus.winner);
      end
   endtask

   task automatic test_p1_wins;
      bit done;
      bit was_tick;
      int over_frames;
      for (int i = 0; i < 4 && m_tick; i++) @(negedge clk);
      start = 1'b1; e1 = 1'b1; @(negedge clk); start = 1'b0; e1 = 1'b0;
      for (int i = 0; i < 40 && !m_tick; i++) @(negedge clk);
      @(negedge clk);
      n_chk++;
      if ({bus.scene, bus.score0, bus.score1, bus.winner} !== {2'd1, 4'd0, 4'd0, 2'd0}) begin
         n_err++; $display("FAIL start_beats_evt: scene/s0/s1/win=%0d/%0d/%0d/%0d want 1/0/0/0", bus.scene, bus.score0, bus.score1, bus.winner);
      end
      done = 1'b0;
      for (int i = 0; i < 20000 && !done; i++) begin
         @(negedge clk);
         e0 = 1'b0; e1 = 1'b0;
         n_chk++;
         if (dut_vec !== mdl_vec) begin
            n_err++; $display("FAIL p1_cycle: got %h want %h", dut_vec, mdl_vec);
         end
         if (m_phase == 1 && $urandom_range(0, 7) == 0) begin
            e1 = 1'b1;
            e0 = (m_s0 < 5) && ($urandom_range(0, 2) == 0);
         end
         done = (d_scene == 3);
      end
      e0 = 1'b0; e1 = 1'b0;
      n_chk++;
      if (bus.scene !== 2'd3 || bus.winner !== 2'd2 || bus.score1 !== 4'd7) begin
         n_err++; $display("FAIL p1_over: scene/win/s1=%0d/%0d/%0d want 3/2/7", bus.scene, bus.winner, bus.score1);
      end
      over_frames = 1;
      was_tick = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 4500 && !done; i++) begin
         @(negedge clk);
         if (was_tick && bus.scene === 2'd3) over_frames++;
         n_chk++;
         if (dut_vec !== mdl_vec) begin
            n_err++; $display("FAIL over_cycle: got %h want %h", dut_vec, mdl_vec);
         end
         was_tick = m_tick;
         done = (d_scene == 0);
      end
      n_chk++;
      if (over_frames != OVER) begin
         n_err++; $display("FAIL over_frames: got %0d want %0d", over_frames, OVER);
      end
      n_chk++;
      if ({bus.scene, bus.score1, bus.winner} !== {2'd0, 4'd7, 2'd2}) begin
         n_err++; $display("FAIL over_timeout_title: scene/s1/win=%0d/%0d/%0d want 0/7/2", bus.scene, bus.score1, bus.winner);
      end
   endtask

   task automatic test_reset_mid_point;
      int ticks;
      for (int i = 0; i < 4 && m_tick; i++) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat ($urandom_range(2, 10)) @(negedge clk);
      e0 = 1'b1; @(negedge clk); e0 = 1'b0;
      ticks = 0;
      for (int i = 0; i < 200 && ticks < 3; i++) begin
         @(negedge clk);
         if (m_tick) ticks++;
         n_chk++;
         if (dut_vec !== mdl_vec) begin
            n_err++; $display("FAIL rstpt_cycle: got %h want %h", dut_vec, mdl_vec);
         end
      end
      rst = 1'b0; @(negedge clk); rst = 1'b1;
      n_chk++;
      if (dut_vec !== 14'd0) begin
         n_err++; $display("FAIL reset_mid_point: got %h want 0", dut_vec);
      end
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         e0 = 1'b0; e1 = 1'b0;
         n_chk++;
         if (dut_vec !== mdl_vec) begin
            n_err++; $display("FAIL post_reset_cycle: got %h want %h", dut_vec, mdl_vec);
         end
         if ($urandom_range(0, 9) == 0) begin
            e0 = 1'($urandom_range(0, 1));
            e1 = 1'($urandom_range(0, 1));
         end
      end
      e0 = 1'b0; e1 = 1'b0;
      n_chk++;
      if ({bus.scene, bus.score0, bus.score1, bus.flash_on, bus.winner} !== 13'd0) begin
         n_err++; $display("FAIL post_reset_idle: scene/s0/s1=%0d/%0d/%0d want 0/0/0", bus.scene, bus.score0, bus.score1);
      end
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      e0    = 1'b0;
      e1    = 1'b0;
      test_reset;
      test_point_flash;
      test_event_on_tick;
      test_draw;
      test_p1_wins;
      test_reset_mid_point;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
